// File: rtl/rv_reg_use_decoder_pkg.sv
// ---------------------------------------------------------------------------
// rv_reg_use_decoder_pkg
// Shared definitions for the RV32I register-usage decoder:
//   - 5-bit major opcode codes (inst[6:2]) for the classes that touch the
//     integer register file
//   - opcode class enumeration
//   - opc_classify(): maps the low opcode bits of an instruction to a class
// ---------------------------------------------------------------------------
package rv_reg_use_decoder_pkg;

    localparam logic [4:0] OPC_R     = 5'b01100;
    localparam logic [4:0] OPC_ICAL  = 5'b00100;
    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_S     = 5'b01000;
    localparam logic [4:0] OPC_B     = 5'b11000;
    localparam logic [4:0] OPC_LUI   = 5'b01101;
    localparam logic [4:0] OPC_AUIPC = 5'b00101;
    localparam logic [4:0] OPC_JAL   = 5'b11011;
    localparam logic [4:0] OPC_JALR  = 5'b11001;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        CLS_R     = 4'd1,
        CLS_ICAL  = 4'd2,
        CLS_LOAD  = 4'd3,
        CLS_S     = 4'd4,
        CLS_B     = 4'd5,
        CLS_LUI   = 4'd6,
        CLS_AUIPC = 4'd7,
        CLS_JAL   = 4'd8,
        CLS_JALR  = 4'd9
    } opc_class_t;

    // opc       : inst[6:0]
    // bubble    : whole instruction word is zero
    // check_low : require inst[1:0]==2'b11 for a valid instruction
    // The all-zero bubble is forced to CLS_NONE explicitly: with the low-bit
    // check disabled its opcode field would otherwise look like a LOAD.
    function automatic opc_class_t opc_classify(input logic [6:0] opc,
                                                input logic       bubble,
                                                input logic       check_low);
        opc_class_t cls;
        cls = CLS_NONE;
        if (!bubble && (!check_low || (opc[1:0] == 2'b11))) begin
            case (opc[6:2])
                OPC_R:     cls = CLS_R;
                OPC_ICAL:  cls = CLS_ICAL;
                OPC_LOAD:  cls = CLS_LOAD;
                OPC_S:     cls = CLS_S;
                OPC_B:     cls = CLS_B;
                OPC_LUI:   cls = CLS_LUI;
                OPC_AUIPC: cls = CLS_AUIPC;
                OPC_JAL:   cls = CLS_JAL;
                OPC_JALR:  cls = CLS_JALR;
                default:   cls = CLS_NONE;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/rv_rd_use.sv
// ---------------------------------------------------------------------------
// rv_rd_use
// Combinational read-usage decode of one RV32I instruction.
// Ports:
//   i_inst  [31:0] instruction word
//   o_re1          instruction reads rs1
//   o_rs1   [4:0]  raw rs1 field inst[19:15]
//   o_re2          instruction reads rs2
//   o_rs2   [4:0]  raw rs2 field inst[24:20]
// ---------------------------------------------------------------------------
module rv_rd_use #(
    parameter int CHECK_LOW_BITS = 1
) (
    input  logic [31:0] i_inst,
    output logic        o_re1,
    output logic [4:0]  o_rs1,
    output logic        o_re2,
    output logic [4:0]  o_rs2
);
    import rv_reg_use_decoder_pkg::*;

    localparam logic CHK = (CHECK_LOW_BITS != 0);

    opc_class_t w_cls;
    logic       w_bubble;

    assign w_bubble = (i_inst == 32'h0000_0000);
    assign w_cls    = opc_classify(i_inst[6:0], w_bubble, CHK);

    assign o_re1 = (w_cls == CLS_R)    || (w_cls == CLS_ICAL) ||
                   (w_cls == CLS_LOAD) || (w_cls == CLS_S)    ||
                   (w_cls == CLS_B)    || (w_cls == CLS_JALR);
    assign o_re2 = (w_cls == CLS_R) || (w_cls == CLS_S) || (w_cls == CLS_B);

    // Register fields are passed through untouched; consumers qualify them
    // with the enables.
    assign o_rs1 = i_inst[19:15];
    assign o_rs2 = i_inst[24:20];

endmodule

// File: rtl/rv_wr_use.sv
// ---------------------------------------------------------------------------
// rv_wr_use
// Combinational write-usage decode of one RV32I instruction.
// Ports:
//   i_inst      [31:0] instruction word
//   o_we_stall         writes a nonzero rd (any writer, including loads)
//   o_we_bypass        writes a nonzero rd whose value is ready at end of E
//   o_ws        [4:0]  raw rd field inst[11:7]
//   o_is_load          instruction is a load
// ---------------------------------------------------------------------------
module rv_wr_use #(
    parameter int CHECK_LOW_BITS = 1
) (
    input  logic [31:0] i_inst,
    output logic        o_we_stall,
    output logic        o_we_bypass,
    output logic [4:0]  o_ws,
    output logic        o_is_load
);
    import rv_reg_use_decoder_pkg::*;

    localparam logic CHK = (CHECK_LOW_BITS != 0);

    opc_class_t w_cls;
    logic       w_bubble;
    logic       w_writer;
    logic       w_rd_nz;

    assign w_bubble = (i_inst == 32'h0000_0000);
    assign w_cls    = opc_classify(i_inst[6:0], w_bubble, CHK);

    assign w_writer = (w_cls == CLS_R)     || (w_cls == CLS_ICAL) ||
                      (w_cls == CLS_LOAD)  || (w_cls == CLS_LUI)  ||
                      (w_cls == CLS_AUIPC) || (w_cls == CLS_JAL)  ||
                      (w_cls == CLS_JALR);

    // x0 is hard-wired zero, so a write to it is never a dependency source.
    assign w_rd_nz = (i_inst[11:7] != 5'd0);

    assign o_is_load   = (w_cls == CLS_LOAD);
    assign o_we_stall  = w_writer && w_rd_nz;
    // Load data only arrives in M, so loads can never be forwarded from E.
    assign o_we_bypass = w_writer && !o_is_load && w_rd_nz;
    assign o_ws        = i_inst[11:7];

endmodule

// File: rtl/rv_reg_use_decoder.sv
// ---------------------------------------------------------------------------
// rv_reg_use_decoder
// Register-usage decoder for the 5-stage RV32I pipeline. Decodes the D-stage
// instruction into read/write usage, keeps an E-stage copy of the write
// descriptor and raises raw load-use / E->D bypass match flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   inst_d      [31:0]         D-stage instruction
//   en                         advance D->E (capture D write descriptor)
//   flush                      load a bubble into E (wins over en)
//   re1_d/rs1_d, re2_d/rs2_d   D read usage
//   we_stall_d/we_bypass_d/ws_d  D write usage
//   we_stall_e/we_bypass_e/ws_e/is_load_e  registered E write descriptor
//   load_use                   D reads a register a load in E will write
//   bypass_a / bypass_b        rs1 / rs2 of D forwarded from E result
// ---------------------------------------------------------------------------
module rv_reg_use_decoder #(
    parameter int CHECK_LOW_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_d,
    input  logic        en,
    input  logic        flush,
    output logic        re1_d,
    output logic [4:0]  rs1_d,
    output logic        re2_d,
    output logic [4:0]  rs2_d,
    output logic        we_stall_d,
    output logic        we_bypass_d,
    output logic [4:0]  ws_d,
    output logic        we_stall_e,
    output logic        we_bypass_e,
    output logic [4:0]  ws_e,
    output logic        is_load_e,
    output logic        load_use,
    output logic        bypass_a,
    output logic        bypass_b
);
    logic       w_is_load_d;
    logic       w_rs1_hit;
    logic       w_rs2_hit;

    logic       r_we_stall_e;
    logic       r_we_bypass_e;
    logic [4:0] r_ws_e;
    logic       r_is_load_e;

    rv_rd_use #(
        .CHECK_LOW_BITS (CHECK_LOW_BITS)
    ) u_rd_use_d (
        .i_inst (inst_d),
        .o_re1  (re1_d),
        .o_rs1  (rs1_d),
        .o_re2  (re2_d),
        .o_rs2  (rs2_d)
    );

    rv_wr_use #(
        .CHECK_LOW_BITS (CHECK_LOW_BITS)
    ) u_wr_use_d (
        .i_inst      (inst_d),
        .o_we_stall  (we_stall_d),
        .o_we_bypass (we_bypass_d),
        .o_ws        (ws_d),
        .o_is_load   (w_is_load_d)
    );

    // E-stage write descriptor. flush has priority over en so a squashed
    // slot always becomes a clean bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_stall_e  <= 1'b0;
            r_we_bypass_e <= 1'b0;
            r_ws_e        <= 5'd0;
            r_is_load_e   <= 1'b0;
        end else if (flush) begin
            r_we_stall_e  <= 1'b0;
            r_we_bypass_e <= 1'b0;
            r_ws_e        <= 5'd0;
            r_is_load_e   <= 1'b0;
        end else if (en) begin
            r_we_stall_e  <= we_stall_d;
            r_we_bypass_e <= we_bypass_d;
            r_ws_e        <= ws_d;
            r_is_load_e   <= w_is_load_d;
        end
    end

    assign we_stall_e  = r_we_stall_e;
    assign we_bypass_e = r_we_bypass_e;
    assign ws_e        = r_ws_e;
    assign is_load_e   = r_is_load_e;

    // The E write enables already exclude rd==x0, so a raw field compare is
    // enough here.
    assign w_rs1_hit = re1_d && (rs1_d == r_ws_e);
    assign w_rs2_hit = re2_d && (rs2_d == r_ws_e);

    assign load_use = r_is_load_e && r_we_stall_e && (w_rs1_hit || w_rs2_hit);
    assign bypass_a = r_we_bypass_e && w_rs1_hit;
    assign bypass_b = r_we_bypass_e && w_rs2_hit;

endmodule

// File: tb/tb_rv_reg_use_decoder.sv
module tb_rv_reg_use_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_d;
    logic        en;
    logic        flush;
    logic        re1_d, re2_d, we_stall_d, we_bypass_d;
    logic [4:0]  rs1_d, rs2_d, ws_d, ws_e;
    logic        we_stall_e, we_bypass_e, is_load_e;
    logic        load_use, bypass_a, bypass_b;

    int n_checks = 0;
    int n_errors = 0;

    rv_reg_use_decoder #(.CHECK_LOW_BITS(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_d      (inst_d),
        .en          (en),
        .flush       (flush),
        .re1_d       (re1_d),
        .rs1_d       (rs1_d),
        .re2_d       (re2_d),
        .rs2_d       (rs2_d),
        .we_stall_d  (we_stall_d),
        .we_bypass_d (we_bypass_d),
        .ws_d        (ws_d),
        .we_stall_e  (we_stall_e),
        .we_bypass_e (we_bypass_e),
        .ws_e        (ws_e),
        .is_load_e   (is_load_e),
        .load_use    (load_use),
        .bypass_a    (bypass_a),
        .bypass_b    (bypass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: behavioural view of what an RV32I instruction does to the
    // register file, keyed on the full 7-bit opcode.
    typedef struct packed {
        logic re1;
        logic re2;
        logic wr;
        logic ld;
    } ref_t;

    function automatic ref_t ref_dec(input logic [31:0] w);
        ref_t r;
        r = '0;
        if (w != 32'h0 && w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h33: begin r.re1 = 1; r.re2 = 1; r.wr = 1; end // OP
                7'h13: begin r.re1 = 1; r.wr = 1; end            // OP-IMM
                7'h03: begin r.re1 = 1; r.wr = 1; r.ld = 1; end  // LOAD
                7'h23: begin r.re1 = 1; r.re2 = 1; end           // STORE
                7'h63: begin r.re1 = 1; r.re2 = 1; end           // BRANCH
                7'h37: r.wr = 1;                                 // LUI
                7'h17: r.wr = 1;                                 // AUIPC
                7'h6F: r.wr = 1;                                 // JAL
                7'h67: begin r.re1 = 1; r.wr = 1; end            // JALR
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Model of the E-stage slot: the instruction word that sits in E.
    logic [31:0] m_inst_e;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst_d=0x%08h E=0x%08h)", tag, obs, exp, inst_d, m_inst_e);
        end
    endtask

    task automatic check_all(input string ctx);
        ref_t d, e;
        logic e_stall, e_byp, d_stall, d_byp;
        logic hit1, hit2;
        d = ref_dec(inst_d);
        e = ref_dec(m_inst_e);
        d_stall = d.wr && (inst_d[11:7] != 0);
        d_byp   = d_stall && !d.ld;
        e_stall = e.wr && (m_inst_e[11:7] != 0);
        e_byp   = e_stall && !e.ld;
        hit1 = d.re1 && (inst_d[19:15] == m_inst_e[11:7]);
        hit2 = d.re2 && (inst_d[24:20] == m_inst_e[11:7]);
        check_val({ctx, ".re1_d"}, 32'(re1_d), 32'(d.re1));
        check_val({ctx, ".re2_d"}, 32'(re2_d), 32'(d.re2));
        check_val({ctx, ".rs1_d"}, 32'(rs1_d), 32'(inst_d[19:15]));
        check_val({ctx, ".rs2_d"}, 32'(rs2_d), 32'(inst_d[24:20]));
        check_val({ctx, ".ws_d"}, 32'(ws_d), 32'(inst_d[11:7]));
        check_val({ctx, ".we_stall_d"}, 32'(we_stall_d), 32'(d_stall));
        check_val({ctx, ".we_bypass_d"}, 32'(we_bypass_d), 32'(d_byp));
        check_val({ctx, ".we_stall_e"}, 32'(we_stall_e), 32'(e_stall));
        check_val({ctx, ".we_bypass_e"}, 32'(we_bypass_e), 32'(e_byp));
        check_val({ctx, ".ws_e"}, 32'(ws_e), 32'(m_inst_e[11:7]));
        check_val({ctx, ".is_load_e"}, 32'(is_load_e), 32'(e.ld));
        check_val({ctx, ".load_use"}, 32'(load_use), 32'(e.ld && e_stall && (hit1 || hit2)));
        check_val({ctx, ".bypass_a"}, 32'(bypass_a), 32'(e_byp && hit1));
        check_val({ctx, ".bypass_b"}, 32'(bypass_b), 32'(e_byp && hit2));
    endtask

    // Drive one cycle's inputs, check everything, then clock the model.
    task automatic step(input string ctx, input logic [31:0] w, input logic e_in, input logic f_in);
        inst_d = w;
        en     = e_in;
        flush  = f_in;
        #1;
        check_all(ctx);
        $display("%s: inst_d=0x%08h en=%0b flush=%0b lu=%0b ba=%0b bb=%0b ws_e=%0d",
                 ctx, w, e_in, f_in, load_use, bypass_a, bypass_b, ws_e);
        @(posedge clk);
        if (f_in)      m_inst_e = 32'h0;
        else if (e_in) m_inst_e = w;
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h37;
            6: w[6:0] = 7'h17;
            7: w[6:0] = 7'h6F;
            8: w[6:0] = 7'h67;
            9: w[6:0] = 7'($urandom);
            default: w = 32'h0;
        endcase
        if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        m_inst_e = 32'h0;
        rst_n  = 1'b0;
        inst_d = 32'h0;
        en     = 1'b0;
        flush  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check_val("reset.we_stall_e", 32'(we_stall_e), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bubble advanced with en keeps E empty.
        step("bubble_en", 32'h0000_0000, 1'b1, 1'b0);
        check_all("bubble_e");

        // add x3,x1,x2
        step("add_d", 32'h0020_81B3, 1'b1, 1'b0);
        check_val("add.ws_e", 32'(ws_e), 32'd3);
        check_val("add.we_bypass_e", 32'(we_bypass_e), 32'd1);

        // Load-use: lw x5,0(x6) in E, addi x7,x5,1 in D.
        step("lw_d", 32'h0003_2283, 1'b1, 1'b0);
        inst_d = 32'h0012_8393; en = 1'b0; #1;
        check_val("lu.load_use", 32'(load_use), 32'd1);
        check_val("lu.bypass_a", 32'(bypass_a), 32'd0);
        step("lu_addi", 32'h0012_8393, 1'b0, 1'b0);
        inst_d = 32'h0000_13B7; #1;
        check_val("lu.lui_load_use", 32'(load_use), 32'd0);
        step("lu_lui", 32'h0000_13B7, 1'b0, 1'b0);

        // Bypass: addi x4,x0,5 in E, sw x4,0(x4) in D.
        step("byp_addi", 32'h0050_0213, 1'b1, 1'b0);
        inst_d = 32'h0042_2023; #1;
        check_val("byp.bypass_a", 32'(bypass_a), 32'd1);
        check_val("byp.bypass_b", 32'(bypass_b), 32'd1);
        check_val("byp.load_use", 32'(load_use), 32'd0);
        step("byp_sw", 32'h0042_2023, 1'b0, 1'b0);

        // x0 destination: addi x0,x1,1 in E, D reads x0 (add x1,x0,x0).
        step("x0_addi", 32'h0010_8013, 1'b1, 1'b0);
        inst_d = 32'h0000_00B3; #1;
        check_val("x0.we_stall_e", 32'(we_stall_e), 32'd0);
        check_val("x0.bypass_a", 32'(bypass_a), 32'd0);
        check_val("x0.bypass_b", 32'(bypass_b), 32'd0);
        step("x0_rd", 32'h0000_00B3, 1'b0, 1'b0);

        // Flush wins over en.
        step("fl_add", 32'h0020_81B3, 1'b1, 1'b0);
        step("fl_both", 32'h0003_2283, 1'b1, 1'b1);
        check_val("flush.ws_e", 32'(ws_e), 32'd0);
        check_val("flush.is_load_e", 32'(is_load_e), 32'd0);

        // Async reset mid-cycle clears E without a clock edge.
        step("ar_add", 32'h0020_81B3, 1'b1, 1'b0);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_inst_e = 32'h0;
        check_val("arst.ws_e", 32'(ws_e), 32'd0);
        check_val("arst.we_stall_e", 32'(we_stall_e), 32'd0);
        check_val("arst.we_bypass_e", 32'(we_bypass_e), 32'd0);
        @(posedge clk);
        #1;
        check_all("arst_hold");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i), rand_inst(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
